aec_expr_tx: RTL and testbench

//  Transmit side of the arithmetic-expression-calculator character link. Host loads expression tokens into an

---
 rtl/aec_expr_tx.sv | 167 ++++++++++++++++
 tb/tb_aec_expr_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/aec_expr_tx.sv
// rtl/aec_expr_tx.sv - expression character-link transmitter: buffers host tokens,
// streams them as ASCII ending in '=', then captures the calculator's answer.
module aec_expr_tx #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_token,
  input  logic       start,
  input  logic       valid_in,
  input  logic [6:0] result_in,
  input  logic       legal_in,
  output logic [7:0] ascii_out,
  output logic       ready_out,
  output logic       busy,
  output logic       wr_full,
  output logic       done,
  output logic [6:0] res_out,
  output logic       res_legal,
  output logic       err
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [TW-1:0] TLAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_TERM, S_WAIT, S_DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   count_q;
  logic [IW-1:0]   idx_q;
  logic [TW-1:0]   timer_q;
  logic [7:0]      ascii_q;
  logic            ready_q;
  logic            done_q;
  logic            err_q;
  logic [6:0]      res_q;
  logic            legal_q;
  logic [4:0]      tok_q [DEPTH];

  logic            wr_ok;
  logic            wr_bad;
  logic [CW-1:0]   count_d;
  logic [IW-1:0]   idx_d;
  logic [4:0]      first_tok;
  logic            last_char;

  function automatic logic [7:0] tok2ascii(input logic [4:0] t);
    logic [7:0] a;
    a = 8'h00;
    case (t)
      5'd16:   a = 8'h28;
      5'd17:   a = 8'h29;
      5'd18:   a = 8'h2A;
      5'd19:   a = 8'h2B;
      5'd20:   a = 8'h2D;
      default: begin
        if (t <= 5'd9)       a = 8'h30 + {3'b000, t};
        else if (t <= 5'd15) a = 8'h57 + {3'b000, t};
      end
    endcase
    return a;
  endfunction

  always_comb begin
    wr_ok     = 1'b0;
    wr_bad    = 1'b0;
    if (wr_en && state_q == S_IDLE) begin
      wr_bad = wr_token > 5'd20;
      wr_ok  = !wr_bad && (count_q < DEPTH_C);
    end
    count_d   = count_q + CW'(wr_ok);
    idx_d     = idx_q + IW'(1);
    // A write landing in the same cycle as start may be the only token.
    first_tok = (count_q == '0) ? wr_token : tok_q[0];
    last_char = (CW'(idx_q) + CW'(1)) == count_q;
  end

  // Token storage is not reset: count_q alone defines what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) tok_q[count_q[IW-1:0]] <= wr_token;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
      ascii_q <= 8'h00;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= 7'd0;
      legal_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          count_q <= count_d;
          if (wr_bad) err_q <= 1'b1;
          if (start) begin
            if (count_d == '0) begin
              err_q <= 1'b1;
            end else begin
              state_q <= S_SEND;
              idx_q   <= '0;
              ascii_q <= tok2ascii(first_tok);
              ready_q <= 1'b1;
            end
          end
        end
        S_SEND: begin
          ready_q <= 1'b0;
          if (last_char) begin
            ascii_q <= 8'h3D;
            state_q <= S_TERM;
          end else begin
            idx_q   <= idx_d;
            ascii_q <= tok2ascii(tok_q[idx_d]);
          end
        end
        S_TERM: begin
          ascii_q <= 8'h00;
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (valid_in) begin
            res_q   <= result_in;
            legal_q <= legal_in;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (timer_q == TLAST) begin
            res_q   <= 7'd0;
            legal_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_DONE: begin
          count_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ascii_out = ascii_q;
  assign ready_out = ready_q;
  assign busy      = state_q != S_IDLE;
  assign wr_full   = count_q == DEPTH_C;
  assign done      = done_q;
  assign res_out   = res_q;
  assign res_legal = legal_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aec_expr_tx.sv
// tb/tb_aec_expr_tx.sv - directed vector table plus hand sequences for aec_expr_tx.
module tb_aec_expr_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_token;
  logic       start;
  logic       valid_in;
  logic [6:0] result_in;
  logic       legal_in;
  logic [7:0] ascii_out;
  logic       ready_out;
  logic       busy;
  logic       wr_full;
  logic       done;
  logic [6:0] res_out;
  logic       res_legal;
  logic       err;

  int n_vec  = 0;
  int n_fail = 0;

  aec_expr_tx #(.DEPTH(16), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_token(wr_token), .start(start),
    .valid_in(valid_in), .result_in(result_in), .legal_in(legal_in),
    .ascii_out(ascii_out), .ready_out(ready_out), .busy(busy), .wr_full(wr_full),
    .done(done), .res_out(res_out), .res_legal(res_legal), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  tok;
    logic        st;
    logic        vld;
    logic [6:0]  rin;
    logic        lin;
    logic [20:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [20:0] o(input logic [7:0] a, input logic r, input logic b,
                                    input logic f, input logic d, input logic e,
                                    input logic [6:0] rs, input logic l);
    return {a, r, b, f, d, e, rs, l};
  endfunction

  function automatic logic [20:0] obs();
    return {ascii_out, ready_out, busy, wr_full, done, err, res_out, res_legal};
  endfunction

  task automatic v(input string nm, input logic we, input logic [4:0] tok, input logic st,
                   input logic vld, input logic [6:0] rin, input logic lin, input logic [20:0] e);
    vec_t x;
    x.name = nm; x.we = we; x.tok = tok; x.st = st; x.vld = vld; x.rin = rin; x.lin = lin; x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic drive(input logic we, input logic [4:0] tok, input logic st,
                       input logic vld, input logic [6:0] rin, input logic lin);
    wr_en = we; wr_token = tok; start = st; valid_in = vld; result_in = rin; legal_in = lin;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Test 1: "3+4", answer 7 legal
    v("t1_w3",   1, 3,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 0, 0));
    v("t1_w19",  1, 19, 0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 0, 0));
    v("t1_w4",   1, 4,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 0, 0));
    v("t1_c0",   0, 0,  1, 0, 0, 0, o(8'h33, 1, 1, 0, 0, 0, 0, 0));
    v("t1_c1",   0, 0,  0, 0, 0, 0, o(8'h2B, 0, 1, 0, 0, 0, 0, 0));
    v("t1_c2",   0, 0,  0, 0, 0, 0, o(8'h34, 0, 1, 0, 0, 0, 0, 0));
    v("t1_eq",   0, 0,  0, 0, 0, 0, o(8'h3D, 0, 1, 0, 0, 0, 0, 0));
    v("t1_wait", 0, 0,  0, 0, 0, 0, o(8'h00, 0, 1, 0, 0, 0, 0, 0));
    v("t1_vld",  0, 0,  0, 1, 7, 1, o(8'h00, 0, 1, 0, 1, 0, 7, 1));
    v("t1_idle", 0, 0,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7, 1));
    // Test 2: "(a*2)"; write/start/valid during SEND must be ignored
    v("t2_w16",  1, 16, 0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7, 1));
    v("t2_w10",  1, 10, 0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7, 1));
    v("t2_w18",  1, 18, 0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7, 1));
    v("t2_w2",   1, 2,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7, 1));
    v("t2_w17",  1, 17, 0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7, 1));
    v("t2_c0",   0, 0,  1, 0, 0, 0, o(8'h28, 1, 1, 0, 0, 0, 7, 1));
    v("t2_c1",   1, 3,  1, 1, 9, 0, o(8'h61, 0, 1, 0, 0, 0, 7, 1));
    v("t2_c2",   0, 0,  0, 0, 0, 0, o(8'h2A, 0, 1, 0, 0, 0, 7, 1));
    v("t2_c3",   0, 0,  0, 0, 0, 0, o(8'h32, 0, 1, 0, 0, 0, 7, 1));
    v("t2_c4",   0, 0,  0, 0, 0, 0, o(8'h29, 0, 1, 0, 0, 0, 7, 1));
    v("t2_eq",   0, 0,  0, 0, 0, 0, o(8'h3D, 0, 1, 0, 0, 0, 7, 1));
    v("t2_wait", 0, 0,  0, 0, 0, 0, o(8'h00, 0, 1, 0, 0, 0, 7, 1));
    v("t2_vld",  0, 0,  0, 1, 7'h55, 0, o(8'h00, 0, 1, 0, 1, 0, 7'h55, 0));
    v("t2_idle", 0, 0,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7'h55, 0));
    // Test 3: empty start
    v("t3_st",   0, 0,  1, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 1, 7'h55, 0));
    v("t3_idle", 0, 0,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7'h55, 0));
    // Test 5 prefix: illegal token, then "5" written together with start
    v("t5_bad",  1, 25, 0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 1, 7'h55, 0));
    v("t5_idle", 0, 0,  0, 0, 0, 0, o(8'h00, 0, 0, 0, 0, 0, 7'h55, 0));
    v("t5_c0",   1, 5,  1, 0, 7'h33, 1, o(8'h35, 1, 1, 0, 0, 0, 7'h55, 0));
    v("t5_eq",   0, 0,  0, 0, 7'h33, 1, o(8'h3D, 0, 1, 0, 0, 0, 7'h55, 0));
    v("t5_wait", 0, 0,  0, 0, 7'h33, 1, o(8'h00, 0, 1, 0, 0, 0, 7'h55, 0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) step();
    chk("reset_state", obs(), o(8'h00, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].tok, tbl[i].st, tbl[i].vld, tbl[i].rin, tbl[i].lin);
      step();
      chk(tbl[i].name, obs(), tbl[i].exp);
    end

    // Test 5 tail: exactly TIMEOUT WAIT cycles, then err+done with cleared result
    for (int i = 1; i <= 64; i++) begin
      step();
      chk($sformatf("t5_to_%0d", i), {done, err, busy}, (i < 64) ? 3'b001 : 3'b111);
    end
    chk("t5_res", {res_out, res_legal}, 8'h00);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t5_idle_after", {busy, done, err}, 3'b000);

    // Test 4: fill to DEPTH, overflow write dropped
    for (int i = 1; i <= 17; i++) begin
      drive(1, 1, 0, 0, 0, 0);
      step();
      chk($sformatf("t4_full_%0d", i), {wr_full, err}, {(i >= 16) ? 1'b1 : 1'b0, 1'b0});
    end
    drive(0, 0, 1, 0, 0, 0);
    step();
    chk("t4_c0", {ascii_out, ready_out}, {8'h31, 1'b1});
    drive(0, 0, 0, 0, 0, 0);
    for (int k = 1; k < 16; k++) begin
      step();
      chk($sformatf("t4_c%0d", k), {ascii_out, ready_out}, {8'h31, 1'b0});
    end
    step();
    chk("t4_eq", {ascii_out, ready_out}, {8'h3D, 1'b0});
    step();
    drive(0, 0, 0, 1, 7'h10, 1);
    step();
    chk("t4_done", obs(), o(8'h00, 0, 1, 1, 1, 0, 7'h10, 1));
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t4_idle", {busy, wr_full}, 2'b00);

    // Test 6: async reset during SEND at idx 2
    for (int i = 0; i < 5; i++) begin
      drive(1, (i % 2 == 1) ? 5'd19 : 5'd1, 0, 0, 0, 0);
      step();
    end
    drive(0, 0, 1, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("t6_idx2", {ascii_out, ready_out, busy}, {8'h31, 1'b0, 1'b1});
    #2 rst = 1'b1;
    #1;
    chk("t6_async_rst", obs(), o(8'h00, 0, 0, 0, 0, 0, 0, 0));
    rst = 1'b0;
    drive(0, 0, 1, 0, 0, 0);
    step();
    chk("t6_empty_after_rst", {busy, err}, 2'b01);
    drive(1, 1, 0, 0, 0, 0);  step();
    drive(1, 19, 0, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0, 0);  step();
    drive(0, 0, 1, 0, 0, 0);  step();
    chk("t6_c0", {ascii_out, ready_out}, {8'h31, 1'b1});
    drive(0, 0, 0, 0, 0, 0);
    step(); chk("t6_c1", {ascii_out, ready_out}, {8'h2B, 1'b0});
    step(); chk("t6_c2", {ascii_out, ready_out}, {8'h31, 1'b0});
    step(); chk("t6_eq", {ascii_out, ready_out}, {8'h3D, 1'b0});
    step(); chk("t6_wait", {ascii_out, busy}, {8'h00, 1'b1});
    drive(0, 0, 0, 1, 7'd2, 1);
    step();
    chk("t6_done", obs(), o(8'h00, 0, 1, 0, 1, 0, 7'd2, 1));
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("t6_idle", obs(), o(8'h00, 0, 0, 0, 0, 0, 7'd2, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
